fp_align_pipe: RTL



---
 rtl/fp_align_pipe.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fp_align_pipe.sv
// Two-stage FP alignment: stage 1 orders the operands by magnitude, stage 2 right-shifts
// the smaller mantissa into a G/R/S field. Define FP_ALIGN_STICKY_EN to fold shifted-out bits into bit 0.
module fp_align_pipe #(
  parameter int MANT_W = 24,
  parameter int EXP_W  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign_1,
  input  logic                in_sign_2,
  input  logic [EXP_W-1:0]    in_exp_1,
  input  logic [EXP_W-1:0]    in_exp_2,
  input  logic [MANT_W-1:0]   in_mant_1,
  input  logic [MANT_W-1:0]   in_mant_2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [MANT_W+2:0]   out_mant_a,
  output logic [MANT_W+2:0]   out_mant_b,
  output logic                out_sign_a,
  output logic                out_sign_b,
  output logic [EXP_W:0]      out_exp,
  output logic                out_swap,
  output logic                out_eff_sub
);
  localparam int EXT_W = MANT_W + 3;

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // A stage loads when it is empty or when the stage after it is loading this cycle.
  logic s1_valid, s2_valid;
  logic s1_load, s2_load;

  assign s2_load   = !s2_valid || out_ready;
  assign s1_load   = !s1_valid || s2_load;
  assign in_ready  = s1_load;
  assign out_valid = s2_valid;

  // Stage 1: magnitude compare and operand routing
  logic              swap_in;
  logic [MANT_W-1:0] mant_a_in, mant_b_in;
  logic [EXP_W-1:0]  exp_a_in, exp_b_in;
  logic              sign_a_in, sign_b_in;

  always_comb begin
    swap_in   = (in_exp_2 > in_exp_1) || ((in_exp_2 == in_exp_1) && (in_mant_2 > in_mant_1));
    mant_a_in = swap_in ? in_mant_2 : in_mant_1;
    mant_b_in = swap_in ? in_mant_1 : in_mant_2;
    exp_a_in  = swap_in ? in_exp_2  : in_exp_1;
    exp_b_in  = swap_in ? in_exp_1  : in_exp_2;
    sign_a_in = swap_in ? in_sign_2 : in_sign_1;
    sign_b_in = swap_in ? in_sign_1 : in_sign_2;
  end

  logic [MANT_W-1:0] s1_mant_a, s1_mant_b;
  logic [EXP_W-1:0]  s1_exp_a, s1_diff;
  logic              s1_sign_a, s1_sign_b, s1_swap, s1_eff_sub;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_mant_a  <= '0;
      s1_mant_b  <= '0;
      s1_exp_a   <= '0;
      s1_diff    <= '0;
      s1_sign_a  <= 1'b0;
      s1_sign_b  <= 1'b0;
      s1_swap    <= 1'b0;
      s1_eff_sub <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mant_a  <= mant_a_in;
        s1_mant_b  <= mant_b_in;
        s1_exp_a   <= exp_a_in;
        s1_diff    <= exp_a_in - exp_b_in;
        s1_sign_a  <= sign_a_in;
        s1_sign_b  <= sign_b_in;
        s1_swap    <= swap_in;
        s1_eff_sub <= in_sign_1 ^ in_sign_2;
      end
    end
  end

  // Stage 2: alignment shift of the smaller operand
  logic [EXT_W-1:0] ext_b, shifted, mant_b_aligned;
  logic             beyond;

  always_comb begin
    ext_b   = {s1_mant_b, 3'b000};
    shifted = ext_b >> s1_diff;
    beyond  = (32'(s1_diff) >= EXT_W);
`ifdef FP_ALIGN_STICKY_EN
    if (beyond)
      mant_b_aligned = {{(EXT_W-1){1'b0}}, |s1_mant_b};
    else
      mant_b_aligned = {shifted[EXT_W-1:1],
                        shifted[0] | (|(ext_b & ~({EXT_W{1'b1}} << s1_diff)))};
`else
    mant_b_aligned = beyond ? '0 : shifted;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      out_mant_a  <= '0;
      out_mant_b  <= '0;
      out_sign_a  <= 1'b0;
      out_sign_b  <= 1'b0;
      out_exp     <= '0;
      out_swap    <= 1'b0;
      out_eff_sub <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_mant_a  <= {s1_mant_a, 3'b000};
        out_mant_b  <= mant_b_aligned;
        out_sign_a  <= s1_sign_a;
        out_sign_b  <= s1_sign_b;
        // Extra MSB gives the carry headroom; all-ones exponent becomes 2^EXP_W.
        out_exp     <= {1'b0, s1_exp_a} + {{EXP_W{1'b0}}, 1'b1};
        out_swap    <= s1_swap;
        out_eff_sub <= s1_eff_sub;
      end
    end
  end
endmodule
